// File: rtl/mul_arb_pkg.sv
// Shared widths and state encoding for the two-requester multiplier arbiter.
package mul_arb_pkg;
  localparam int X_W   = 8;
  localparam int Y_W   = 4;
  localparam int P_W   = 12;
  localparam int N_REQ = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/CSAM2C.sv
// Combinational two's-complement array multiplier (Baugh-Wooley partial products).
module CSAM2C
  import mul_arb_pkg::*;
#(
  parameter int DATA_W = X_W,
  parameter int COEF_W = Y_W
) (
  output logic signed [DATA_W+COEF_W-1:0] product,
  input  logic signed [DATA_W-1:0]        X,
  input  logic signed [COEF_W-1:0]        Y
);
  localparam int PW = DATA_W + COEF_W;
  localparam logic [PW-1:0] ONE = 1;
  // Correction constant replacing the negative-weight sign rows
  localparam logic [PW-1:0] BW_CORR = (ONE << (PW - 1)) + (ONE << (DATA_W - 1)) + (ONE << (COEF_W - 1));

  logic [PW-1:0] acc;
  logic [PW-1:0] row;

  always_comb begin
    acc = BW_CORR;
    row = '0;
    for (int i = 0; i < COEF_W; i++) begin
      row = '0;
      for (int j = 0; j < DATA_W; j++) begin
        row[j] = (X[j] & Y[i]) ^ ((j == DATA_W - 1) != (i == COEF_W - 1));
      end
      acc = acc + (row << i);
    end
    product = acc;
  end
endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one CSAM2C multiplier between two requesters.
// Optional per-requester grant counters when MUL_ARB_STATS_EN is defined.
module mul_arbiter
  import mul_arb_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ-1:0][X_W-1:0]      req_x,
  input  logic [N_REQ-1:0][Y_W-1:0]      req_y,
  output logic [N_REQ-1:0]               req_ready,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic signed [P_W-1:0]          res_prod,
  output logic                           res_id
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [15:0]                    grant_cnt0,
  output logic [15:0]                    grant_cnt1
`endif
);
  state_t                 state;
  logic                   last_p0;
  logic                   slot_free;
  logic                   xfer;
  logic                   sel;
  logic signed [X_W-1:0]  x_p0;
  logic signed [Y_W-1:0]  y_p0;
  logic signed [P_W-1:0]  prod_p0;

  // Grant stage: slot frees when empty or being drained this cycle
  always_comb begin
    req_ready = '0;
    slot_free = (state == EMPTY) || res_ready;
    if (!reset && slot_free) begin
      case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = last_p0 ? 2'b01 : 2'b10;
        default: req_ready = 2'b00;
      endcase
    end
  end

  assign xfer = |req_ready;
  assign sel  = req_ready[1];
  assign x_p0 = req_x[sel];
  assign y_p0 = req_y[sel];

  CSAM2C #(
    .DATA_W(X_W),
    .COEF_W(Y_W)
  ) u_mul (
    .product(prod_p0),
    .X      (x_p0),
    .Y      (y_p0)
  );

  // Result register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      res_prod <= '0;
      res_id   <= 1'b0;
      last_p0  <= 1'b1;
`ifdef MUL_ARB_STATS_EN
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
`endif
    end else if (xfer) begin
      state    <= FULL;
      res_prod <= prod_p0;
      res_id   <= sel;
      last_p0  <= sel;
`ifdef MUL_ARB_STATS_EN
      if (sel) grant_cnt1 <= grant_cnt1 + 16'd1;
      else     grant_cnt0 <= grant_cnt0 + 16'd1;
`endif
    end else if (res_ready) begin
      state <= EMPTY;
    end
  end

  assign res_valid = (state == FULL);
endmodule
